// File: rtl/e_branch_resolve_pkg.sv
// Shared encodings for E-stage branch resolution and the
// direction predictor's 2-bit counters.
package e_branch_resolve_pkg;

    localparam logic [1:0] JC_NONE   = 2'b00;
    localparam logic [1:0] JC_BRANCH = 2'b01;
    localparam logic [1:0] JC_JAL    = 2'b10;
    localparam logic [1:0] JC_JALR   = 2'b11;

    localparam logic [2:0] BC_EQ  = 3'b000;
    localparam logic [2:0] BC_NE  = 3'b001;
    localparam logic [2:0] BC_LT  = 3'b100;
    localparam logic [2:0] BC_GE  = 3'b101;
    localparam logic [2:0] BC_LTU = 3'b110;
    localparam logic [2:0] BC_GEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // A miss restarts the entry at the weak state matching the outcome.
    function automatic logic [1:0] ctr_next(
        input logic       hit,
        input logic       taken,
        input logic [1:0] ctr
    );
        logic [1:0] n;
        if (!hit)
            n = taken ? CTR_WT : CTR_WNT;
        else if (taken)
            n = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        else
            n = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/e_branch_resolve_table.sv
// Direct-mapped, tagged predictor table with 2-bit counters.
// Lookup is registered and sees pre-update contents on a same-index write.
module e_bpred_table
    import e_branch_resolve_pkg::*;
#(
    parameter int PC_W  = 13,
    parameter int IDX_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_upd_en,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic [PC_W-1:0] i_upd_target,
    input  logic            i_upd_taken,
    input  logic            i_lkp_valid,
    input  logic [PC_W-1:0] i_lkp_pc,
    output logic            o_pred_valid,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_target
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic             r_valid [ENTRIES];
    logic [1:0]       r_ctr   [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [PC_W-1:0]  r_tgt   [ENTRIES];

    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [PC_W-1:0]  r_pred_target;

    logic [IDX_W-1:0] w_up_idx;
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_up_hit;
    logic             w_lk_taken;

    assign w_up_idx = i_upd_pc[IDX_W-1:0];
    assign w_lk_idx = i_lkp_pc[IDX_W-1:0];

    assign w_up_hit = r_valid[w_up_idx]
                   && (r_tag[w_up_idx] == i_upd_pc[PC_W-1:IDX_W]);

    assign w_lk_taken = r_valid[w_lk_idx]
                     && (r_tag[w_lk_idx] == i_lkp_pc[PC_W-1:IDX_W])
                     && r_ctr[w_lk_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_WNT;
            end
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            if (i_upd_en) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= ctr_next(w_up_hit, i_upd_taken,
                                              r_ctr[w_up_idx]);
            end
            r_pred_valid  <= i_lkp_valid;
            r_pred_taken  <= w_lk_taken;
            r_pred_target <= w_lk_taken ? r_tgt[w_lk_idx]
                                        : i_lkp_pc + PC_W'(1);
        end
    end

    // Tag and target storage needs no reset: guarded by r_valid.
    always_ff @(posedge clk) begin
        if (i_upd_en) begin
            r_tag[w_up_idx] <= i_upd_pc[PC_W-1:IDX_W];
            r_tgt[w_up_idx] <= i_upd_target;
        end
    end

    assign o_pred_valid  = r_pred_valid;
    assign o_pred_taken  = r_pred_taken;
    assign o_pred_target = r_pred_target;

endmodule

// File: rtl/e_branch_resolve.sv
// E-stage control-transfer resolution: computes the real next PC,
// flags mispredictions, trains the predictor table, keeps statistics.
module e_branch_resolve
    import e_branch_resolve_pkg::*;
#(
    parameter int PC_W  = 13,
    parameter int IDX_W = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_predicted,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] reg_data1,
    input  logic [XLEN-1:0] reg_data2,
    input  logic [1:0]      jump_code,
    input  logic [2:0]      branch_code,
    input  logic            cannot_calcpc,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    output logic            out_valid,
    output logic [PC_W-1:0] nextpc,
    output logic            fail_predict,
    output logic [31:0]     branch_count,
    output logic [31:0]     miss_count
);

    logic [PC_W-1:0] w_base;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next;
    logic            w_cond;
    logic            w_taken;
    logic            w_accept;
    logic            w_is_cti;
    logic            w_fail;
    logic            w_unused_imm;

    logic            r_out_valid;
    logic            r_fail;
    logic [PC_W-1:0] r_nextpc;
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_miss_cnt;

    // Immediates are byte offsets; PCs are word addresses.
    assign w_base   = (jump_code == JC_JALR) ? reg_data1[PC_W+1:2] : pc;
    assign w_target = imm[PC_W+1:2] + w_base;

    always_comb begin
        w_cond = 1'b0;
        case (branch_code)
            BC_EQ:   w_cond = (reg_data1 == reg_data2);
            BC_NE:   w_cond = (reg_data1 != reg_data2);
            BC_LT:   w_cond = ($signed(reg_data1) <  $signed(reg_data2));
            BC_GE:   w_cond = ($signed(reg_data1) >= $signed(reg_data2));
            BC_LTU:  w_cond = (reg_data1 <  reg_data2);
            BC_GEU:  w_cond = (reg_data1 >= reg_data2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken  = jump_code[1] | ((jump_code == JC_BRANCH) & w_cond);
    assign w_next   = w_taken ? w_target : pc + PC_W'(1);
    assign w_accept = in_valid & ~flush;
    assign w_is_cti = (jump_code != JC_NONE);
    assign w_fail   = w_accept & cannot_calcpc & (w_next != pc_predicted);

    assign w_unused_imm = ^{imm[XLEN-1:PC_W+2], imm[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_fail       <= 1'b0;
            r_nextpc     <= '0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_out_valid <= w_accept;
            r_fail      <= w_fail;
            if (w_accept)
                r_nextpc <= w_next;
            if (w_accept && w_is_cti && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_fail && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    e_bpred_table #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_tbl (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_upd_en      (w_accept & w_is_cti),
        .i_upd_pc      (pc),
        .i_upd_target  (w_target),
        .i_upd_taken   (w_taken),
        .i_lkp_valid   (lookup_valid),
        .i_lkp_pc      (lookup_pc),
        .o_pred_valid  (pred_valid),
        .o_pred_taken  (pred_taken),
        .o_pred_target (pred_target)
    );

    assign out_valid    = r_out_valid;
    assign fail_predict = r_fail;
    assign nextpc       = r_nextpc;
    assign branch_count = r_branch_cnt;
    assign miss_count   = r_miss_cnt;

endmodule
